// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter FSM state type and line levels.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/flex_pts_sr.sv
// flex_pts_sr: parallel-to-serial shift register, load beats shift, fills with ones.
module flex_pts_sr #(
    parameter int NUM_BITS  = 4,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);
    logic [NUM_BITS-1:0] q;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) q <= '1;
        else if (load_enable) q <= parallel_in;
        else if (shift_enable) q <= SHIFT_MSB ? {q[NUM_BITS-2:0], 1'b1} : {1'b1, q[NUM_BITS-1:1]};
    assign serial_out = SHIFT_MSB ? q[NUM_BITS-1] : q[0];
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1-style UART transmitter with registered line output.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    tx_state_t   state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic        sr_out, wrap, load, shift;
    assign wrap  = cnt == CW'(CLKS_PER_BIT - 1);
    assign load  = state == IDLE && tx_start;
    // Shifting at the end of START too keeps the next payload bit ready at every wrap.
    assign shift = wrap && (state == START || state == DATA);
    flex_pts_sr #(.NUM_BITS(DATA_BITS), .SHIFT_MSB(1'b0)) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (load),
        .shift_enable (shift),
        .parallel_in  (tx_data),
        .serial_out   (sr_out)
    );
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            serial_out <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            cnt     <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
            case (state)
                IDLE:
                    if (tx_start) begin
                        state      <= START;
                        serial_out <= START_BIT;
                        tx_busy    <= 1'b1;
                    end
                START:
                    if (wrap) begin
                        state      <= DATA;
                        serial_out <= sr_out;
                        idx        <= '0;
                    end
                DATA:
                    if (wrap) begin
                        if (idx == IW'(DATA_BITS - 1)) begin
                            state      <= STOP;
                            serial_out <= STOP_BIT;
                        end else begin
                            idx        <= idx + 1'b1;
                            serial_out <= sr_out;
                        end
                    end
                STOP:
                    if (wrap) begin
                        state      <= IDLE;
                        serial_out <= IDLE_LEVEL;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame checks for 10- and 2-cycle bit periods.
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic n_rst;
    logic [7:0] data0, data1;
    logic start0, start1;
    logic so0, busy0, done0, so1, busy1, done1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(data0), .tx_start(start0),
        .serial_out(so0), .tx_busy(busy0), .tx_done(done0)
    );
    uart_transmitter #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(data1), .tx_start(start1),
        .serial_out(so1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accepting edge; returns in the tx_done cycle.
    task automatic expect_frame(input string tag, input logic [7:0] d, input int cpb,
                                input bit fast, input int inj);
        logic e;
        for (int b = 0; b < 10; b++) begin
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            for (int c = 0; c < cpb; c++) begin
                check($sformatf("%s line b%0d c%0d", tag, b, c), fast ? so1 : so0, e);
                check($sformatf("%s busy b%0d c%0d", tag, b, c), fast ? busy1 : busy0, 1);
                check($sformatf("%s done b%0d c%0d", tag, b, c), fast ? done1 : done0, 0);
                if (b * cpb + c == inj) begin
                    start0 = 1'b1;
                    data0  = 8'hFF;
                end
                tick;
                if (b * cpb + c == inj) start0 = 1'b0;
            end
        end
        check({tag, " end done"}, fast ? done1 : done0, 1);
        check({tag, " end busy"}, fast ? busy1 : busy0, 0);
        check({tag, " end line"}, fast ? so1 : so0, 1);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s line %0d", tag, i), so0, 1);
            check($sformatf("%s busy %0d", tag, i), busy0, 0);
            check($sformatf("%s done %0d", tag, i), done0, 0);
            tick;
        end
    endtask

    initial begin
        n_rst = 1'b0; start0 = 1'b0; start1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        tick;
        check("rst line", so0, 1);
        check("rst busy", busy0, 0);
        check("rst done", done0, 0);
        check("rst line fast", so1, 1);
        n_rst = 1'b1;
        expect_idle("idle", 20);

        data0 = 8'hA5; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        expect_frame("a5", 8'hA5, 10, 1'b0, -1);
        tick;
        expect_idle("a5 after", 3);

        data0 = 8'h3C; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        expect_frame("3c", 8'h3C, 10, 1'b0, 35);
        tick;
        expect_idle("3c after", 15);

        data0 = 8'h00; start0 = 1'b1;
        tick;
        data0 = 8'hFF;
        expect_frame("hold 00", 8'h00, 10, 1'b0, -1);
        tick;
        start0 = 1'b0;
        expect_frame("hold ff", 8'hFF, 10, 1'b0, -1);
        tick;
        expect_idle("hold after", 3);

        data0 = 8'h55; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (47) tick;
        check("pre-rst line", so0, 0);
        n_rst = 1'b0;
        #1;
        check("abort line", so0, 1);
        check("abort busy", busy0, 0);
        check("abort done", done0, 0);
        tick;
        n_rst = 1'b1;
        expect_idle("post-rst", 60);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        expect_frame("55", 8'h55, 10, 1'b0, -1);

        data1 = 8'h81; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        expect_frame("fast 81", 8'h81, 2, 1'b1, -1);
        tick;
        check("fast after done", done1, 0);
        check("fast after busy", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit period; legal range 2-1023.
REQ-002 Parameter DATA_BITS, default 8: payload width, sent LSB first.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  DATA_BITS  payload; sampled only on the accepting cycle.
REQ-006 tx_start  input  1  frame request; level-sampled each cycle.
REQ-007 serial_out  output  1  UART line; idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 Frame SHALL be: one start bit (0), DATA_BITS payload bits (LSB first), one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 In IDLE, serial_out SHALL be 1, tx_busy 0.
REQ-013 IDLE->START when tx_start=1; tx_data SHALL be captured into the shift register on that edge.
REQ-014 Latency: serial_out SHALL drop to 0 the cycle after tx_start is sampled high; tx_busy SHALL rise on the same edge.
REQ-015 A bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; the wrap cycle ends the current bit.
REQ-016 START->DATA on bit-counter wrap; DATA SHALL shift once per wrap; DATA->STOP after DATA_BITS wraps, tracked by a bit-index counter.
REQ-017 STOP->IDLE on bit-counter wrap; tx_done SHALL be 1 for exactly the first IDLE cycle after STOP.
REQ-018 tx_start while tx_busy=1 SHALL be ignored: no re-capture, no frame restart, no queuing.
REQ-019 tx_start high in the tx_done cycle SHALL be accepted, giving back-to-back frames with no idle bit between stop and start.
REQ-020 tx_start held high continuously SHALL produce consecutive frames, each recapturing tx_data.
REQ-021 Total frame length SHALL be (DATA_BITS+2)*CLKS_PER_BIT cycles, from the first low cycle to the tx_done cycle exclusive.
REQ-022 tx_data changes after the accepting cycle SHALL NOT affect the frame in progress.
REQ-023 serial_out SHALL be driven from a register (glitch-free).

Reset
REQ-024 On n_rst=0, asynchronously and regardless of state: FSM=IDLE, counters=0, shift register all ones, serial_out=1, tx_busy=0, tx_done=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the line SHALL return high immediately, and no tx_done SHALL be produced.
REQ-026 After reset release, the first tx_start SHALL be accepted on the first rising edge.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum typedef, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
REQ-028 The serializer SHALL be sub-module flex_pts_sr: parameters NUM_BITS and SHIFT_MSB (0 here); ports load_enable, shift_enable, parallel_in, serial_out; resets to all ones; load has priority over shift.
REQ-029 Timer and bit-index counters and the FSM SHALL reside in uart_transmitter; no other sub-modules.

Verification
REQ-030 Reset, idle 20 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout.
REQ-031 tx_data=8'hA5, one-cycle tx_start, CLKS_PER_BIT=10 -> line 0, then 1,0,1,0,0,1,0,1, then 1, each for 10 cycles; tx_done pulses at cycle 100 after the start bit begins.
REQ-032 tx_data=8'h3C; pulse tx_start again, with tx_data=8'hFF, at cycle 35 -> second request ignored, frame carries 8'h3C, exactly one tx_done.
REQ-033 tx_start held high, tx_data=8'h00 then 8'hFF -> two contiguous 100-cycle frames, no extra idle bit, two tx_done pulses.
REQ-034 n_rst pulsed low at cycle 47 of a frame with 8'h55 -> serial_out=1 and tx_busy=0 immediately; no tx_done; a new 8'h55 frame is correct afterwards.
REQ-035 CLKS_PER_BIT=2, tx_data=8'h81 -> bit durations of 2 cycles, 20-cycle frame, correct LSB-first order.
